// File: rtl/uart_transmitter.sv
// uart_transmitter: byte FIFO feeding an 8N1 serializer onto tx.
// Ports: clk, rst_n (async low), valid/data in, full/done/tx out.
module uart_transmitter #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       done,
  output logic       full,
  output logic       tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_transmitter: CLK_FREQ/BAUD_RATE must be >= 2");
  end
  if (FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_transmitter: FIFO_DEPTH must be a power of 2 >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          stop_end_q, stop_end_d;
  logic          done_q;
  logic          full_q, full_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic wr_en;
  logic pop;
  logic empty;
  logic baud_last;

  assign wr_en     = valid && !full_q;
  assign empty     = (count_q == '0);
  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q + CW'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    tx_d       = 1'b1;
    stop_end_d = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          baud_d     = '0;
          stop_end_d = 1'b1;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            bit_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data;
  end

  // tx trails the FSM by one cycle, so done is delayed one more
  // cycle to land just after the stop bit leaves the pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      stop_end_q <= 1'b0;
      done_q     <= 1'b0;
      full_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      stop_end_q <= stop_end_d;
      done_q     <= stop_end_q;
      full_q     <= full_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign tx   = tx_q;
  assign done = done_q;
  assign full = full_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed scenario tasks for uart_transmitter.
// CLKS_PER_BIT=10, FIFO_DEPTH=4; a line decoder collects frames.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       done;
  logic       full;
  logic       tx;

  int checks = 0;
  int errors = 0;

  uart_transmitter #(
    .CLK_FREQ  (1_000_000),
    .BAUD_RATE (100_000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .valid(valid),
    .data (data),
    .done (done),
    .full (full),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  logic [7:0] fr_q [$];
  int         fall_q [$];
  int         done_q [$];
  logic [9:0] last_bits = '0;
  int         frame_err = 0;

  int         cyc = 0;
  bit         busy = 0;
  int         fall_c = 0;
  int         off = 0;
  logic [9:0] acc = '0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      busy = 0;
    end else begin
      if (done === 1'b1) done_q.push_back(cyc);
      if (!busy && tx === 1'b0) begin
        busy = 1;
        fall_c = cyc;
      end
      if (busy) begin
        off = cyc - fall_c;
        if (off % 10 == 5) begin
          acc[off/10] = tx;
          if (off / 10 == 9) begin
            busy = 0;
            last_bits = acc;
            fr_q.push_back(acc[8:1]);
            fall_q.push_back(fall_c);
            if (acc[0] !== 1'b0 || acc[9] !== 1'b1)
              frame_err++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [7:0] b);
    valid = 1'b1;
    data  = b;
    tick();
    valid = 1'b0;
  endtask

  task automatic clear_mon();
    fr_q.delete();
    fall_q.delete();
    done_q.delete();
    frame_err = 0;
  endtask

  task automatic wait_dones(input int n, input int budget);
    int k;
    k = 0;
    while (done_q.size() < n && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ticks(3);
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL rst_tx: got %b want 1", tx);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL rst_done: got %b want 0", done);
    end
    checks++;
    if (full !== 1'b0) begin
      errors++;
      $display("FAIL rst_full: got %b want 0", full);
    end
    rst_n = 1'b1;
    ticks(5);
    checks++;
    if (tx !== 1'b1 || done !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL post_rst: tx=%b done=%b full=%b want 1 0 0",
               tx, done, full);
    end
  endtask

  task automatic test_single();
    logic [9:0] exp_bits;
    exp_bits = 10'b1101001010;
    clear_mon();
    wr(8'hA5);
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL single_e0: tx got %b want 1", tx);
    end
    tick();
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL single_e1: tx got %b want 1", tx);
    end
    tick();
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL single_e2: tx got %b want 0", tx);
    end
    wait_dones(1, 200);
    ticks(30);
    checks++;
    if (fr_q.size() != 1 || done_q.size() != 1) begin
      errors++;
      $display("FAIL single_cnt: frames=%0d dones=%0d want 1 1",
               fr_q.size(), done_q.size());
    end else begin
      checks++;
      if (last_bits !== exp_bits) begin
        errors++;
        $display("FAIL single_bits: got %b want %b",
                 last_bits, exp_bits);
      end
      checks++;
      if (done_q[0] - fall_q[0] != 100) begin
        errors++;
        $display("FAIL single_done_lat: got %0d want 100",
                 done_q[0] - fall_q[0]);
      end
    end
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL single_idle: tx got %b want 1", tx);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    exp = '{8'h00, 8'hFF, 8'h3C};
    clear_mon();
    wr(8'h00);
    wr(8'hFF);
    wr(8'h3C);
    wait_dones(3, 450);
    ticks(20);
    checks++;
    if (fr_q.size() != 3 || done_q.size() != 3) begin
      errors++;
      $display("FAIL b2b_cnt: frames=%0d dones=%0d want 3 3",
               fr_q.size(), done_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (fr_q[i] !== exp[i]) begin
          errors++;
          $display("FAIL b2b_byte%0d: got %h want %h",
                   i, fr_q[i], exp[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (fall_q[i] - fall_q[i-1] != 100 ||
            done_q[i] - done_q[i-1] != 100) begin
          errors++;
          $display("FAIL b2b_gap%0d: frame %0d done %0d want 100",
                   i, fall_q[i] - fall_q[i-1],
                   done_q[i] - done_q[i-1]);
        end
      end
      checks++;
      if (done_q[0] - fall_q[0] != 100) begin
        errors++;
        $display("FAIL b2b_done_lat: got %0d want 100",
                 done_q[0] - fall_q[0]);
      end
    end
    checks++;
    if (frame_err != 0) begin
      errors++;
      $display("FAIL b2b_framing: got %0d bad frames want 0",
               frame_err);
    end
  endtask

  task automatic test_overflow();
    clear_mon();
    wr(8'h01);
    wr(8'h02);
    wr(8'h03);
    wr(8'h04);
    checks++;
    if (full !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full4: got %b want 0", full);
    end
    wr(8'h05);
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL ovf_full5: got %b want 1", full);
    end
    wr(8'h06);
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL ovf_full6: got %b want 1", full);
    end
    wait_dones(5, 700);
    ticks(150);
    checks++;
    if (fr_q.size() != 5 || done_q.size() != 5) begin
      errors++;
      $display("FAIL ovf_cnt: frames=%0d dones=%0d want 5 5",
               fr_q.size(), done_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (fr_q[i] !== 8'(i + 1)) begin
          errors++;
          $display("FAIL ovf_byte%0d: got %h want %h",
                   i, fr_q[i], 8'(i + 1));
        end
      end
    end
  endtask

  task automatic test_pop_write_full();
    logic [7:0] exp [6];
    exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h77};
    clear_mon();
    wr(8'hA0);
    wr(8'hA1);
    wr(8'hA2);
    wr(8'hA3);
    wr(8'hA4);
    ticks(96);
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL pw_full_before: got %b want 1", full);
    end
    valid = 1'b1;
    data  = 8'hEE;
    tick();
    checks++;
    if (full !== 1'b0) begin
      errors++;
      $display("FAIL pw_full_after_pop: got %b want 0", full);
    end
    data = 8'h77;
    tick();
    valid = 1'b0;
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL pw_full_refill: got %b want 1", full);
    end
    wait_dones(6, 800);
    ticks(150);
    checks++;
    if (fr_q.size() != 6 || done_q.size() != 6) begin
      errors++;
      $display("FAIL pw_cnt: frames=%0d dones=%0d want 6 6",
               fr_q.size(), done_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (fr_q[i] !== exp[i]) begin
          errors++;
          $display("FAIL pw_byte%0d: got %h want %h",
                   i, fr_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    wr(8'h5A);
    wr(8'h11);
    wr(8'h22);
    ticks(43);
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL mid_bit3: tx got %b want 1", tx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || full !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst: tx=%b full=%b done=%b want 1 0 0",
               tx, full, done);
    end
    ticks(3);
    rst_n = 1'b1;
    clear_mon();
    ticks(300);
    checks++;
    if (fr_q.size() != 0 || done_q.size() != 0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL mid_quiet: frames=%0d dones=%0d tx=%b want 0 0 1",
               fr_q.size(), done_q.size(), tx);
    end
    wr(8'h5A);
    wait_dones(1, 200);
    ticks(20);
    checks++;
    if (fr_q.size() != 1 || done_q.size() != 1) begin
      errors++;
      $display("FAIL mid_new_cnt: frames=%0d dones=%0d want 1 1",
               fr_q.size(), done_q.size());
    end else begin
      checks++;
      if (fr_q[0] !== 8'h5A) begin
        errors++;
        $display("FAIL mid_new_byte: got %h want 5a", fr_q[0]);
      end
    end
  endtask

  task automatic test_wrap();
    int n;
    int k;
    clear_mon();
    n = 0;
    k = 0;
    while (n < 12 && k < 3000) begin
      if (full === 1'b0) begin
        valid = 1'b1;
        data  = 8'h10 + 8'(n);
        n++;
      end else begin
        valid = 1'b0;
      end
      tick();
      k++;
    end
    valid = 1'b0;
    checks++;
    if (n != 12) begin
      errors++;
      $display("FAIL wrap_accept: got %0d writes want 12", n);
    end
    wait_dones(12, 1500);
    ticks(150);
    checks++;
    if (fr_q.size() != 12 || done_q.size() != 12) begin
      errors++;
      $display("FAIL wrap_cnt: frames=%0d dones=%0d want 12 12",
               fr_q.size(), done_q.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (fr_q[i] !== 8'h10 + 8'(i)) begin
          errors++;
          $display("FAIL wrap_byte%0d: got %h want %h",
                   i, fr_q[i], 8'h10 + 8'(i));
        end
      end
    end
    checks++;
    if (frame_err != 0) begin
      errors++;
      $display("FAIL wrap_framing: got %0d bad frames want 0",
               frame_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_pop_write_full();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit stage of the UART: accepts bytes from the controller through the `uart_tx_if` signal set (`valid`, `data`, `done`, `full`), buffers them in an internal FIFO and serializes each byte onto the `tx` line as an 8N1 frame. It sits between the controller and the board TX pin.

## Interface
- `CLK_FREQ`, default 50_000_000. System clock frequency in Hz.
- `BAUD_RATE`, default 115_200. Line rate in bit/s.
- `FIFO_DEPTH`, default 16. TX FIFO entries; power of 2, at least 2.
- Derived: `CLKS_PER_BIT = CLK_FREQ / BAUD_RATE`, using integer division. It must be at least 2, enforced by an elaboration-time check.

Ports:
- `clk`  input  1  system clock; the block has one clock domain.
- `rst_n`  input  1  asynchronous, active-low reset.
- `valid`  input  1  write strobe; `data` is written into the FIFO on each rising edge where `valid`=1 and `full`=0.
- `data`  input  8  byte to send.
- `done`  output  1  one-cycle pulse when a frame's stop bit completes.
- `full`  output  1  FIFO holds `FIFO_DEPTH` bytes.
- `tx`  output  1  serial line; idles high.

## Operation
- FIFO:
  - Circular buffer with read/write pointers and a count register of width log2(`FIFO_DEPTH`)+1.
  - `full` = (count == `FIFO_DEPTH`), a registered decode with no combinational path from `valid`.
  - A write while `full`=1 is dropped silently; FIFO contents and pointers are unchanged.
  - A write and a pop in the same cycle: count is unchanged and both pointers advance.
  - A pop and a write while `full`=1: the pop occurs and the write is dropped, because `full` was high at the edge.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Frame format: start bit (0), data[0]..data[7] LSB first, stop bit (1). There is no parity.
- FSM states:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop into the shift register, clear the bit counter and baud counter, and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `tx` = shift_reg[0] and each bit is held `CLKS_PER_BIT` cycles. Shift right after each bit. After bit 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. On the last cycle, assert `done` (registered, visible the following cycle). If the FIFO is non-empty, pop and go directly to START; otherwise go to IDLE.
- Baud counter: counts 0..`CLKS_PER_BIT`-1, is reset on each state entry, and is not free-running.
- `tx` is driven from a register, so the output is glitch-free.

## Timing
- Reset values: `tx`=1, `done`=0, `full`=0, FSM=IDLE, FIFO empty, all counters 0.
- Reset asserted mid-frame forces `tx`=1 immediately (asynchronously). The frame in progress and all queued bytes are discarded.
- Latency from an idle FIFO:
  - Write accepted at edge E; FIFO becomes non-empty after E.
  - Pop at edge E+1.
  - `tx` falls at edge E+2.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles.
- `done` is high for exactly one cycle, starting the cycle after the last stop-bit cycle. That is 10×`CLKS_PER_BIT` cycles after `tx` fell.
- Back-to-back frames: the next start bit begins on the cycle immediately after the stop bit. There is no extra idle cycle.
- Per accepted byte, exactly one `done` pulse is produced, in FIFO order. Dropped writes produce none.
- `full` updates the cycle after the write or pop that changes count.

## Test plan
Run with `CLK_FREQ`=1_000_000, `BAUD_RATE`=100_000 (`CLKS_PER_BIT`=10), `FIFO_DEPTH`=4.

- Single byte: write 0xA5 from idle -> `tx` falls 2 cycles later and the sampled bits are 0,1,0,1,0,0,1,0,1,1. `done` pulses once, 100 cycles after the fall. `tx` then stays 1.
- Back-to-back: write 0x00, 0xFF, 0x3C on consecutive cycles -> three contiguous 100-cycle frames with no idle gap. Decoded bytes are 0x00, 0xFF, 0x3C, with 3 `done` pulses spaced 100 cycles apart.
- Full/overflow: write 6 bytes 0x01..0x06 on consecutive cycles starting from idle. One byte is popped into the shifter after the first write, so `full` rises after the 5th write and the 6th is dropped. Result: 5 frames (0x01..0x05) and 5 `done` pulses.
- Simultaneous pop/write at full: with the FIFO full, assert `valid` on the STOP→START pop cycle -> that byte is dropped. `full` deasserts the next cycle, and a write on that cycle is accepted.
- Reset mid-frame: assert `rst_n`=0 during bit 3 of 0x5A with 2 bytes queued -> `tx`=1 at once and `full`=0. After release, no frame and no `done` occur until a new write.
- Pointer wrap: stream 12 bytes 0x10..0x1B, writing whenever `full`=0 -> all 12 decoded in order and 12 `done` pulses.
